// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port memory between instruction fetch and data ports.
// Request to ack is 2 cycles, one access per 3 cycles; requesters hold req until their ack.
`ifndef IMEMSIZE
`define IMEMSIZE 10
`endif
`ifndef WORDSIZE
`define WORDSIZE 32
`endif

module mem_arbiter #(
  parameter int MEMSIZE  = `IMEMSIZE,
  parameter int WORDSIZE = `WORDSIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [MEMSIZE-1:0]  if_addr,
  output logic                if_ack,
  output logic [WORDSIZE-1:0] if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [MEMSIZE-1:0]  dm_addr,
  input  logic [WORDSIZE-1:0] dm_wdata,
  output logic                dm_ack,
  output logic [WORDSIZE-1:0] dm_rdata,
  output logic                mem_wren,
  output logic                mem_rden,
  output logic [MEMSIZE-1:0]  mem_addr,
  output logic [WORDSIZE-1:0] mem_d,
  input  logic [WORDSIZE-1:0] mem_q
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  logic [1:0] state;
  logic       last_grant;
  logic       sel_dm;
  logic       sel_write;
  logic       grant_dm;
  logic       any_req;

  assign any_req = if_req | dm_req;

  // On a tie the port that was not served last time wins.
  assign grant_dm = dm_req & (~if_req | (last_grant == PORT_IF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= PORT_IF;
      sel_dm     <= PORT_IF;
      sel_write  <= 1'b0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_wren   <= 1'b0;
      mem_rden   <= 1'b0;
      mem_addr   <= '0;
      mem_d      <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= ACCESS;
            last_grant <= grant_dm ? PORT_DM : PORT_IF;
            sel_dm     <= grant_dm ? PORT_DM : PORT_IF;
            sel_write  <= grant_dm & dm_we;
            mem_addr   <= grant_dm ? dm_addr : if_addr;
            if (grant_dm) begin
              mem_d <= dm_wdata;
            end
            // Enables are registered here so they are high exactly for the ACCESS cycle.
            mem_wren   <= grant_dm & dm_we;
            mem_rden   <= ~(grant_dm & dm_we);
          end
        end
        ACCESS: begin
          mem_wren <= 1'b0;
          mem_rden <= 1'b0;
          if (!sel_write) begin
            if (sel_dm == PORT_DM) begin
              dm_rdata <= mem_q;
            end else begin
              if_rdata <= mem_q;
            end
          end
          if_ack <= (sel_dm == PORT_IF);
          dm_ack <= (sel_dm == PORT_DM);
          state  <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_wren;
  logic          mem_rden;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  // Memory environment: combinational read, write on the rising edge.
  logic [DW-1:0] tb_mem [0:255];
  logic          mem_init = 1'b0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_dat = '0;

  // Model's view of memory contents.
  logic [DW-1:0] model_mem [0:255];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign mem_q = tb_mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (pl_en) begin
      tb_mem[pl_addr] <= pl_dat;
    end else if (mem_wren) begin
      tb_mem[mem_addr] <= mem_d;
    end
  end

  mem_arbiter #(.MEMSIZE(AW), .WORDSIZE(DW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_d(mem_d),
    .mem_q(mem_q)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    mem_init = 1'b1;
    tick();
    tick();
    mem_init = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'hA500_0000 | 32'(i);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    tick();
    pl_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Issues one access, holds req until ack, then idles one cycle.
  task automatic port_access(input bit dm, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, output int lat, output int nwr,
                             output int nrd, output logic [DW-1:0] d_seen,
                             output logic [AW-1:0] a_seen);
    lat = -1; nwr = 0; nrd = 0; d_seen = '0; a_seen = '0;
    if (dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      tick();
      if (mem_wren === 1'b1) begin nwr++; d_seen = mem_d; a_seen = mem_addr; end
      if (mem_rden === 1'b1) begin nrd++; a_seen = mem_addr; end
      if ((dm ? dm_ack : if_ack) === 1'b1) lat = i;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({if_ack, dm_ack, mem_wren, mem_rden} !== 4'b0)
      $display("FAIL reset_ctrl: got %b want 0000", {if_ack, dm_ack, mem_wren, mem_rden});
    else passes++;
    checks++;
    if ({if_rdata, dm_rdata} !== '0)
      $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, dm_rdata);
    else passes++;
    checks++;
    if ({mem_addr, mem_d} !== '0)
      $display("FAIL reset_mem_bus: got addr %h d %h want 0/0", mem_addr, mem_d);
    else passes++;
    rst = 1'b0;
    tick();
    checks++;
    if ({if_ack, dm_ack, mem_wren, mem_rden} !== 4'b0)
      $display("FAIL reset_idle: got %b want 0000", {if_ack, dm_ack, mem_wren, mem_rden});
    else passes++;
  endtask

  task automatic test_if_read();
    preload(8'd5, 32'hDEAD_BEEF);
    if_addr = 8'd5;
    if_req = 1'b1;
    tick();
    checks++;
    if (mem_rden !== 1'b1 || mem_wren !== 1'b0 || mem_addr !== 8'd5)
      $display("FAIL if_read_access: got rden %b wren %b addr %0d want 1 0 5", mem_rden, mem_wren, mem_addr);
    else passes++;
    checks++;
    if (if_ack !== 1'b0)
      $display("FAIL if_read_early_ack: got %b want 0", if_ack);
    else passes++;
    tick();
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== 32'hDEAD_BEEF)
      $display("FAIL if_read_ack: got ack %b data %h want 1 deadbeef", if_ack, if_rdata);
    else passes++;
    checks++;
    if (mem_rden !== 1'b0 || mem_wren !== 1'b0 || dm_ack !== 1'b0)
      $display("FAIL if_read_resp_bus: got rden %b wren %b dm_ack %b want 0 0 0", mem_rden, mem_wren, dm_ack);
    else passes++;
    if_req = 1'b0;
    tick();
    checks++;
    if (if_ack !== 1'b0 || if_rdata !== 32'hDEAD_BEEF)
      $display("FAIL if_read_after: got ack %b data %h want 0 deadbeef", if_ack, if_rdata);
    else passes++;
  endtask

  task automatic test_dm_store_load();
    int lat, nwr, nrd;
    logic [DW-1:0] d_seen;
    logic [AW-1:0] a_seen;
    port_access(1'b1, 1'b1, 8'd9, 32'h1234_5678, lat, nwr, nrd, d_seen, a_seen);
    model_mem[9] = 32'h1234_5678;
    checks++;
    if (lat != 2 || nwr != 1 || nrd != 0)
      $display("FAIL dm_store_shape: got lat %0d wren %0d rden %0d want 2 1 0", lat, nwr, nrd);
    else passes++;
    checks++;
    if (d_seen !== 32'h1234_5678 || a_seen !== 8'd9)
      $display("FAIL dm_store_bus: got d %h addr %0d want 12345678 9", d_seen, a_seen);
    else passes++;
    checks++;
    if (dm_rdata !== 32'h0)
      $display("FAIL dm_store_rdata_kept: got %h want 0", dm_rdata);
    else passes++;
    port_access(1'b1, 1'b0, 8'd9, 32'h0, lat, nwr, nrd, d_seen, a_seen);
    checks++;
    if (lat != 2 || nwr != 0 || nrd != 1)
      $display("FAIL dm_load_shape: got lat %0d wren %0d rden %0d want 2 0 1", lat, nwr, nrd);
    else passes++;
    checks++;
    if (dm_rdata !== 32'h1234_5678)
      $display("FAIL dm_load_data: got %h want 12345678", dm_rdata);
    else passes++;
  endtask

  task automatic test_tie();
    int  ev_cyc[$];
    bit  ev_dm[$];
    bit  overlap = 1'b0;
    do_reset();
    if_addr = 8'd5; dm_we = 1'b0; dm_addr = 8'd9;
    if_req = 1'b1; dm_req = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (if_ack === 1'b1 && dm_ack === 1'b1) overlap = 1'b1;
      if (if_ack === 1'b1) begin ev_cyc.push_back(t); ev_dm.push_back(1'b0); end
      if (dm_ack === 1'b1) begin ev_cyc.push_back(t); ev_dm.push_back(1'b1); end
      if (t == 11) begin if_req = 1'b0; dm_req = 1'b0; end
    end
    checks++;
    if (overlap || ev_cyc.size() != 4)
      $display("FAIL tie_count: got %0d acks overlap %b want 4 acks overlap 0", ev_cyc.size(), overlap);
    else passes++;
    for (int k = 0; k < 4 && k < ev_cyc.size(); k++) begin
      checks++;
      if (ev_cyc[k] != 2 + 3 * k || ev_dm[k] != ((k % 2) == 0))
        $display("FAIL tie_order_%0d: got cycle %0d dm %b want cycle %0d dm %b",
                 k, ev_cyc[k], ev_dm[k], 2 + 3 * k, (k % 2) == 0);
      else passes++;
    end
    checks++;
    if (if_rdata !== model_mem[5] || dm_rdata !== model_mem[9])
      $display("FAIL tie_data: got %h/%h want %h/%h", if_rdata, dm_rdata, model_mem[5], model_mem[9]);
    else passes++;
  endtask

  task automatic test_dm_during_if();
    int if_t = -1;
    int dm_t = -1;
    tick();
    if_addr = 8'd5; if_req = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 1) begin dm_we = 1'b0; dm_addr = 8'd3; dm_req = 1'b1; end
      if (if_ack === 1'b1 && if_t < 0) begin if_t = t; if_req = 1'b0; end
      if (dm_ack === 1'b1 && dm_t < 0) begin dm_t = t; dm_req = 1'b0; end
    end
    checks++;
    if (if_t != 2 || dm_t != 5)
      $display("FAIL late_dm_timing: got if_ack %0d dm_ack %0d want 2 5", if_t, dm_t);
    else passes++;
    checks++;
    if (dm_rdata !== model_mem[3])
      $display("FAIL late_dm_data: got %h want %h", dm_rdata, model_mem[3]);
    else passes++;
  endtask

  task automatic test_reset_mid_access();
    int acks = 0;
    int first_t = -1;
    bit first_dm = 1'b0;
    int if_t = -1;
    dm_we = 1'b1; dm_addr = 8'd7; dm_wdata = 32'hCAFE_F00D; dm_req = 1'b1;
    tick();
    checks++;
    if (mem_wren !== 1'b1)
      $display("FAIL rst_mid_pre: got wren %b want 1", mem_wren);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_wren !== 1'b0 || mem_rden !== 1'b0 || dm_ack !== 1'b0 || mem_addr !== 8'd0)
      $display("FAIL rst_mid_drop: got wren %b rden %b ack %b addr %0d want 0 0 0 0",
               mem_wren, mem_rden, dm_ack, mem_addr);
    else passes++;
    dm_req = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (t == 1) rst = 1'b0;
      if (dm_ack === 1'b1 || if_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0)
      $display("FAIL rst_mid_no_ack: got %0d acks want 0", acks);
    else passes++;
    if_addr = 8'd7; dm_we = 1'b0; dm_addr = 8'd2;
    if_req = 1'b1; dm_req = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (dm_ack === 1'b1) begin
        if (first_t < 0) begin first_t = t; first_dm = 1'b1; end
        dm_req = 1'b0;
      end
      if (if_ack === 1'b1) begin
        if (first_t < 0) begin first_t = t; first_dm = 1'b0; end
        if (if_t < 0) if_t = t;
        if_req = 1'b0;
      end
    end
    checks++;
    if (first_t != 2 || first_dm != 1'b1 || if_t != 5)
      $display("FAIL rst_tie_dm_first: got first %0d dm %b if_ack %0d want 2 1 5", first_t, first_dm, if_t);
    else passes++;
    checks++;
    if (if_rdata !== model_mem[7] || dm_rdata !== model_mem[2])
      $display("FAIL rst_dropped_write: got %h/%h want %h/%h", if_rdata, dm_rdata, model_mem[7], model_mem[2]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int lat, nwr, nrd;
    logic [DW-1:0] d_seen;
    logic [AW-1:0] a_seen;
    int ack_t[$];
    logic [AW-1:0] a = 8'd20;
    port_access(1'b1, 1'b0, 8'd1, 32'h0, lat, nwr, nrd, d_seen, a_seen);
    if_addr = a; if_req = 1'b1;
    for (int t = 1; t <= 12 && ack_t.size() < 3; t++) begin
      tick();
      if (if_ack === 1'b1) begin
        ack_t.push_back(t);
        checks++;
        if (if_rdata !== model_mem[if_addr])
          $display("FAIL b2b_data_%0d: got %h want %h", ack_t.size(), if_rdata, model_mem[if_addr]);
        else passes++;
        a = a + 8'd1;
        if_addr = a;
      end
    end
    if_req = 1'b0;
    tick();
    checks++;
    if (ack_t.size() != 3)
      $display("FAIL b2b_count: got %0d acks want 3", ack_t.size());
    else if (ack_t[0] != 2 || ack_t[1] != 5 || ack_t[2] != 8)
      $display("FAIL b2b_spacing: got %0d %0d %0d want 2 5 8", ack_t[0], ack_t[1], ack_t[2]);
    else passes++;
  endtask

  // Randomized traffic against a transaction-level model: one access at a time, round-robin on ties.
  task automatic test_random();
    int  next_free = 0;
    int  ack_at = -10;
    bit  ack_dm = 1'b0;
    bit  exp_wr = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_d = '0;
    logic [DW-1:0] exp_val = '0;
    bit  last_dm = 1'b0;
    bit  win_dm;
    int  errs = 0;
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      checks++;
      if (if_ack !== (ack_at == t && !ack_dm) || dm_ack !== (ack_at == t && ack_dm)) begin
        errs++;
        $display("FAIL rand_ack t=%0d: got if %b dm %b want if %b dm %b",
                 t, if_ack, dm_ack, ack_at == t && !ack_dm, ack_at == t && ack_dm);
      end else passes++;
      checks++;
      if (t == ack_at - 1) begin
        if (mem_wren !== exp_wr || mem_rden !== !exp_wr || mem_addr !== exp_addr ||
            (exp_wr && mem_d !== exp_d)) begin
          errs++;
          $display("FAIL rand_access t=%0d: got wren %b rden %b addr %0d d %h want %b %b %0d %h",
                   t, mem_wren, mem_rden, mem_addr, mem_d, exp_wr, !exp_wr, exp_addr, exp_d);
        end else passes++;
      end else if (mem_wren !== 1'b0 || mem_rden !== 1'b0) begin
        errs++;
        $display("FAIL rand_idle_bus t=%0d: got wren %b rden %b want 0 0", t, mem_wren, mem_rden);
      end else passes++;
      if (t == ack_at && !exp_wr) begin
        checks++;
        if ((ack_dm ? dm_rdata : if_rdata) !== exp_val) begin
          errs++;
          $display("FAIL rand_rdata t=%0d: got %h want %h", t, ack_dm ? dm_rdata : if_rdata, exp_val);
        end else passes++;
      end
      if (errs > 20) break;
      if (t == ack_at) begin
        if (ack_dm) dm_req = 1'b0; else if_req = 1'b0;
      end else begin
        if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = 8'($urandom_range(0, 15));
        end
        if (!dm_req && $urandom_range(0, 2) == 0) begin
          dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
          dm_addr = 8'($urandom_range(0, 15)); dm_wdata = $urandom;
        end
      end
      if (t >= next_free && (if_req || dm_req)) begin
        win_dm    = dm_req && (!if_req || !last_dm);
        last_dm   = win_dm;
        ack_dm    = win_dm;
        ack_at    = t + 2;
        next_free = t + 3;
        exp_wr    = win_dm && dm_we;
        exp_addr  = win_dm ? dm_addr : if_addr;
        exp_d     = dm_wdata;
        if (exp_wr) model_mem[exp_addr] = exp_d;
        else exp_val = model_mem[exp_addr];
      end
      tick();
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_store_load();
    test_tie();
    test_dm_during_if();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
